cache_ctrl_fsm: RTL

// Sequencing controller for the direct-mapped cache. Accepts one read/write request at a time
// and drives the tag lookup. On a miss it runs the dirty-victim writeback and the line fill

---
 rtl/cache_ctrl_fsm_if.sv | 41 ++++
 rtl/cache_ctrl_fsm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm_if.sv
// ============================================================================
//  Module   : cache_ctrl_fsm_if
//  Brief    : Request, tag-lookup and memory handshake bundle for cache_ctrl_fsm.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface cache_ctrl_fsm_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 req_valid;
    logic                 req_we;
    logic                 req_ready;
    logic                 hit;
    logic                 victim_dirty;
    logic                 lookup;
    logic                 mem_we;
    logic                 mem_re;
    logic                 mem_ack;
    logic                 fill_en;
    logic                 array_we;
    logic                 done;
    logic                 error;
    logic [CNT_WIDTH-1:0] hit_count;
    logic [CNT_WIDTH-1:0] miss_count;

    // The controller is the slave of this bundle; requester, tag array and memory form the master.
    modport slave (
        input  req_valid, req_we, hit, victim_dirty, mem_ack,
        output req_ready, lookup, mem_we, mem_re, fill_en, array_we, done, error,
               hit_count, miss_count
    );

    modport master (
        output req_valid, req_we, hit, victim_dirty, mem_ack,
        input  req_ready, lookup, mem_we, mem_re, fill_en, array_we, done, error,
               hit_count, miss_count
    );
endinterface

`default_nettype wire

// File: rtl/cache_ctrl_fsm.sv
// ============================================================================
//  Module   : cache_ctrl_fsm
//  Brief    : Direct-mapped cache sequencer: lookup, victim writeback, line fill
//             with memory timeout, array access and saturating hit/miss counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cache_ctrl_fsm #(
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic             clk,
    input  wire logic             rst,
    cache_ctrl_fsm_if.slave       bus
);

    localparam int c_timer_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max    = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_FILL      = 3'd3,
        S_ACCESS    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 op_we_q, op_we_d;
    logic [c_timer_w-1:0] timer_q, timer_d;
    logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
    logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

    logic w_req_ready;
    logic w_lookup;
    logic w_mem_we;
    logic w_mem_re;
    logic w_fill_en;
    logic w_array_we;
    logic w_done;
    logic w_error;
    logic w_timeout;

    assign w_timeout = (timer_q == c_timer_last) && !bus.mem_ack;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_we_q      <= 1'b0;
            timer_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            op_we_q      <= op_we_d;
            timer_q      <= timer_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_we_d      = op_we_q;
        timer_d      = timer_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        w_req_ready  = 1'b0;
        w_lookup     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;
        w_fill_en    = 1'b0;
        w_array_we   = 1'b0;
        w_done       = 1'b0;
        w_error      = 1'b0;

        case (state_q)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_we_d = bus.req_we;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_lookup = 1'b1;
                timer_d  = '0;
                if (bus.hit) begin
                    state_d = S_ACCESS;
                    if (hit_count_q != c_cnt_max) begin
                        hit_count_d = hit_count_q + c_cnt_one;
                    end
                end else begin
                    state_d = bus.victim_dirty ? S_WRITEBACK : S_FILL;
                    if (miss_count_q != c_cnt_max) begin
                        miss_count_d = miss_count_q + c_cnt_one;
                    end
                end
            end
            S_WRITEBACK: begin
                w_mem_we = 1'b1;
                if (bus.mem_ack) begin
                    state_d = S_FILL;
                    timer_d = '0;
                end else if (w_timeout) begin
                    w_error = 1'b1;
                    w_done  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + c_timer_one;
                end
            end
            S_FILL: begin
                w_mem_re = 1'b1;
                if (bus.mem_ack) begin
                    w_fill_en = 1'b1;
                    state_d   = S_ACCESS;
                end else if (w_timeout) begin
                    w_error = 1'b1;
                    w_done  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + c_timer_one;
                end
            end
            S_ACCESS: begin
                w_array_we = op_we_q;
                w_done     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset is level-qualified on the outputs so nothing leaks while rst is held low.
    assign bus.req_ready  = rst & w_req_ready;
    assign bus.lookup     = rst & w_lookup;
    assign bus.mem_we     = rst & w_mem_we;
    assign bus.mem_re     = rst & w_mem_re;
    assign bus.fill_en    = rst & w_fill_en;
    assign bus.array_we   = rst & w_array_we;
    assign bus.done       = rst & w_done;
    assign bus.error      = rst & w_error;
    assign bus.hit_count  = rst ? hit_count_q  : '0;
    assign bus.miss_count = rst ? miss_count_q : '0;

endmodule

`default_nettype wire
